// File: rtl/jk_bank_arbiter_if.sv
// Command/handshake bundle between two control masters and the shared JK bank arbiter.
// The master side drives commands; the slave side (arbiter) returns ready/status and bank state.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_mask;
  logic [CNT_W-1:0] req0_rpt;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_mask;
  logic [CNT_W-1:0] req1_rpt;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             grant_id;
  logic             done;

  modport master (
    output req0_valid, req0_op, req0_mask, req0_rpt,
    output req1_valid, req1_op, req1_mask, req1_rpt,
    input  req0_ready, req1_ready, q, busy, grant_id, done
  );

  modport slave (
    input  req0_valid, req0_op, req0_mask, req0_rpt,
    input  req1_valid, req1_op, req1_mask, req1_rpt,
    output req0_ready, req1_ready, q, busy, grant_id, done
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter owning a WIDTH-bit JK flip-flop bank; each granted command drives
// J/K of the masked bits for rpt+1 consecutive edges, then pulses done.
//
// state   | meaning
// IDLE    | arbitrating; ready offered to the winning valid requester
// EXEC    | applying the latched op once per edge until counter reaches rpt
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst,
  jk_bank_arbiter_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             gid_q, gid_d;
  logic             done_q, done_d;

  logic             win;
  logic             acc0;
  logic             acc1;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    win = 1'b0;
    if (bus.req0_valid && bus.req1_valid) win = ~ptr_q;
    else if (bus.req1_valid)              win = 1'b1;
  end

  // Ready is masked while rst is high so nothing looks accepted during reset.
  assign acc0 = ~rst & (state_q == ST_IDLE) & bus.req0_valid & ~win;
  assign acc1 = ~rst & (state_q == ST_IDLE) & bus.req1_valid &  win;

  assign j_vec = mask_q & {WIDTH{op_q[1]}};
  assign k_vec = mask_q & {WIDTH{op_q[0]}};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mask_d  = mask_q;
    op_d    = op_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (acc0 || acc1) begin
        op_d    = acc1 ? bus.req1_op   : bus.req0_op;
        mask_d  = acc1 ? bus.req1_mask : bus.req0_mask;
        rpt_d   = acc1 ? bus.req1_rpt  : bus.req0_rpt;
        gid_d   = win;
        ptr_d   = win;
        cnt_d   = '0;
        state_d = ST_EXEC;
      end
    end else begin
      q_d   = (j_vec & ~q_q) | (~k_vec & q_q);
      cnt_d = cnt_q + 1'b1;
      // Leave before the counter can wrap when rpt is all ones.
      if (cnt_q == rpt_q) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      mask_q  <= '0;
      op_q    <= 2'b00;
      rpt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gid_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
    end
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.q          = q_q;
  assign bus.busy       = (state_q == ST_EXEC);
  assign bus.grant_id   = gid_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: command-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_jk_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  bit clk = 1'b0;
  bit rst = 1'b0;
  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  jk_bank_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: a command is "apply op to the mask, rpt+1 times"
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_mask;
  logic [1:0]       m_op;
  int               m_left;
  bit               m_busy, m_done, m_gid, m_last, m_acc0, m_acc1;
  bit               a0, a1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int r);
    bit w;
    if (m_busy) return 1'b0;
    if (bus.req0_valid && bus.req1_valid) w = ~m_last;
    else w = bus.req1_valid;
    if (r == 0) return bus.req0_valid && !w;
    return bus.req1_valid && w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = '0; m_mask = '0; m_op = 2'b00; m_left = 0;
      m_busy = 0; m_done = 0; m_gid = 0; m_last = 1; m_acc0 = 0; m_acc1 = 0;
    end else begin
      a0 = exp_rdy(0);
      a1 = exp_rdy(1);
      m_acc0 = a0;
      m_acc1 = a1;
      if (m_busy) begin
        case (m_op)
          2'b01: m_q = m_q & ~m_mask;
          2'b10: m_q = m_q | m_mask;
          2'b11: m_q = m_q ^ m_mask;
          default: ;
        endcase
        m_left--;
        m_done = (m_left == 0);
        if (m_left == 0) m_busy = 0;
      end else begin
        m_done = 0;
        if (a0 || a1) begin
          m_op   = a1 ? bus.req1_op   : bus.req0_op;
          m_mask = a1 ? bus.req1_mask : bus.req0_mask;
          m_left = (a1 ? int'(bus.req1_rpt) : int'(bus.req0_rpt)) + 1;
          m_busy = 1;
          m_gid  = a1;
          m_last = a1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_q",      bus.q,          m_q);
      check("cyc_busy",   bus.busy,       m_busy);
      check("cyc_done",   bus.done,       m_done);
      check("cyc_gid",    bus.grant_id,   m_gid);
      check("cyc_ready0", bus.req0_ready, exp_rdy(0));
      check("cyc_ready1", bus.req1_ready, exp_rdy(1));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit v, input logic [1:0] op,
                         input logic [WIDTH-1:0] mask, input logic [CNT_W-1:0] rpt);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_mask = mask; bus.req0_rpt = rpt;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_mask = mask; bus.req1_rpt = rpt;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && bus.busy; i++) tick();
    check("wait_idle", bus.busy, 1'b0);
  endtask

  task automatic run_cmd(input int r, input logic [1:0] op,
                         input logic [WIDTH-1:0] mask, input logic [CNT_W-1:0] rpt);
    bit acc;
    acc = 0;
    set_req(r, 1'b1, op, mask, rpt);
    for (int i = 0; i < 20 && !acc; i++) begin
      tick();
      acc = (r == 0) ? m_acc0 : m_acc1;
    end
    check("run_cmd_accept", acc, 1'b1);
    if (r == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    wait_idle();
    tick();
  endtask

  int nb, nd, ng;
  logic gids [4];
  logic q0s  [4];

  initial begin
    set_req(0, 1'b0, 2'b00, '0, '0);
    set_req(1, 1'b0, 2'b00, '0, '0);
    #1 rst = 1'b1;

    // 1: reset with req0 waiting
    set_req(0, 1'b1, 2'b00, 8'h00, 4'd0);
    tick(); tick();
    check("t1_q",      bus.q,          8'h00);
    check("t1_busy",   bus.busy,       1'b0);
    check("t1_done",   bus.done,       1'b0);
    check("t1_gid",    bus.grant_id,   1'b0);
    check("t1_ready0", bus.req0_ready, 1'b0);
    rst = 1'b0;
    #1 check("t1_ready0_rel", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    wait_idle();
    tick();

    // 2: set upper nibble
    set_req(0, 1'b1, 2'b10, 8'hF0, 4'd0);
    tick();
    check("t2_busy", bus.busy, 1'b1);
    check("t2_q_acc", bus.q, 8'h00);
    bus.req0_valid = 1'b0;
    tick();
    check("t2_q",    bus.q,        8'hF0);
    check("t2_done", bus.done,     1'b1);
    check("t2_busy_off", bus.busy, 1'b0);
    check("t2_gid",  bus.grant_id, 1'b0);
    tick();
    check("t2_done_off", bus.done, 1'b0);

    // 3: toggle lower nibble three times
    set_req(1, 1'b1, 2'b11, 8'h0F, 4'd2);
    tick();
    check("t3_ready1_exec", bus.req1_ready, 1'b0);
    check("t3_gid", bus.grant_id, 1'b1);
    bus.req1_valid = 1'b0;
    tick();
    check("t3_q1", bus.q, 8'hFF);
    check("t3_done1", bus.done, 1'b0);
    tick();
    check("t3_q2", bus.q, 8'hF0);
    tick();
    check("t3_q3", bus.q, 8'hFF);
    check("t3_done3", bus.done, 1'b1);
    tick();

    // 4: both held continuously, alternating grants
    rst = 1'b1;
    set_req(0, 1'b1, 2'b10, 8'h01, 4'd0);
    set_req(1, 1'b1, 2'b01, 8'h01, 4'd0);
    tick();
    rst = 1'b0;
    ng = 0;
    for (int i = 0; i < 16 && ng < 4; i++) begin
      tick();
      if (bus.done) begin
        gids[ng] = bus.grant_id;
        q0s[ng]  = bus.q[0];
        if (ng < 3) check("t4_back2back", bus.req0_ready | bus.req1_ready, 1'b1);
        ng++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("t4_count", ng, 4);
    for (int k = 0; k < ng; k++) begin
      check("t4_gid", gids[k], k % 2);
      check("t4_q0",  q0s[k],  (k % 2 == 0) ? 1 : 0);
    end
    wait_idle();
    tick();

    // 5: long hold at max repeat count, then reset op
    run_cmd(0, 2'b01, 8'hFF, 4'd0);
    run_cmd(0, 2'b10, 8'hA5, 4'd0);
    check("t5_pre", bus.q, 8'hA5);
    set_req(0, 1'b1, 2'b00, 8'hFF, 4'd15);
    tick();
    bus.req0_valid = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      nb += int'(bus.busy);
      tick();
      nd += int'(bus.done);
    end
    check("t5_busy_cycles", nb, 16);
    check("t5_done_count",  nd, 1);
    check("t5_q_hold",      bus.q, 8'hA5);
    set_req(0, 1'b1, 2'b01, 8'hFF, 4'd15);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("t5_q_reset", bus.q, 8'h00);
    wait_idle();
    tick();

    // 6: reset in the middle of a toggle burst, then re-arbitration
    set_req(1, 1'b1, 2'b11, 8'hFF, 4'd7);
    tick(); tick(); tick(); tick();
    check("t6_q_mid", bus.q, 8'hFF);
    rst = 1'b1;
    #1;
    check("t6_rst_q",    bus.q,    8'h00);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_done", bus.done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_reacc_busy", bus.busy, 1'b1);
    check("t6_reacc_gid",  bus.grant_id, 1'b1);
    bus.req1_valid = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      nb += int'(bus.busy);
      tick();
      if (i == 0) check("t6_first_app", bus.q, 8'hFF);
      nd += int'(bus.done);
    end
    check("t6_apps",  nb, 8);
    check("t6_dones", nd, 1);
    check("t6_final", bus.q, 8'h00);

    // random phase; fields stay frozen while a request is pending
    for (int c = 0; c < 3000; c++) begin
      if (bus.req0_valid && !m_acc0) begin
        if ($urandom_range(0, 15) == 0) bus.req0_valid = 1'b0;
      end else begin
        set_req(0, 1'($urandom_range(0, 1)), 2'($urandom), WIDTH'($urandom),
                ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
      end
      if (bus.req1_valid && !m_acc1) begin
        if ($urandom_range(0, 15) == 0) bus.req1_valid = 1'b0;
      end else begin
        set_req(1, 1'($urandom_range(0, 1)), 2'($urandom), WIDTH'($urandom),
                ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
Shares one WIDTH-bit bank of JK flip-flops between two requesters. Each requester issues a command: an operation (hold/reset/set/toggle), a bit mask and a repeat count. A round-robin arbiter grants one command at a time. An FSM then drives the J/K inputs of the masked bits for (rpt+1) consecutive clock edges and pulses done. The block sits between control masters and the JK register bank, and owns that bank exclusively.

Parameters:
WIDTH, 8, number of JK flip-flops in the bank (1..32)
CNT_W, 4, width of the repeat-count field; max applications = 2^CNT_W

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a command
req0_ready  output  1  requester 0 command accepted this cycle
req0_op  input  2  requester 0 op: 00 hold, 01 reset, 10 set, 11 toggle
req0_mask  input  WIDTH  requester 0 bits affected (1 = apply op)
req0_rpt  input  CNT_W  requester 0 repeat count; applications = rpt+1
req1_valid  input  1  requester 1 has a command
req1_ready  output  1  requester 1 command accepted this cycle
req1_op  input  2  requester 1 op, encoding as req0_op
req1_mask  input  WIDTH  requester 1 mask
req1_rpt  input  CNT_W  requester 1 repeat count
q  output  WIDTH  JK bank state
busy  output  1  command executing (state EXEC)
grant_id  output  1  requester owning the current or most recent command
done  output  1  one-cycle pulse: command finished

Behaviour:
- Reset (rst high, asynchronous): q=0, busy=0, done=0, grant_id=0, state=IDLE, repeat counter=0, last-grant pointer=1, so req0 wins the first tie.
- Bank update, per bit i, on each application edge:
  - j_i = mask_i & op[1]; k_i = mask_i & op[0].
  - q_i <= (j_i & ~q_i) | (~k_i & q_i).
  - Unmasked bits and hold op: q unchanged.
  - q changes only in EXEC.
- FSM states: IDLE, EXEC.
- IDLE:
  - ready is combinational, high only for the granted requester, and only when its valid is high.
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to the last-grant pointer is granted.
  - Accept edge (valid & ready): latch op/mask/rpt; grant_id <= winner; pointer <= winner; counter <= 0; go to EXEC.
  - No bank change on the accept edge.
- EXEC:
  - ready0 = ready1 = 0.
  - Every edge applies the latched op and increments the counter.
  - On the edge where counter == latched rpt: apply, set done <= 1, go to IDLE.
  - done is high for exactly the following cycle and cleared next edge unless another command completes.
- Latency:
  - Accept edge t0; applications at edges t0+1 .. t0+1+rpt.
  - busy high for rpt+1 cycles; done high during the cycle after the final application edge.
- Back-to-back: in the cycle done is high, state is IDLE, so a new command can be accepted in that cycle. Sustained throughput is one command per rpt+2 cycles.
- Requester rule: op/mask/rpt must be stable while valid is high and ready is low. A requester may drop valid before grant; no command is then taken.
- Latched command is immune to input changes during EXEC.
- rpt = 2^CNT_W-1: counter must not wrap before completion; exactly 2^CNT_W applications.
- mask = 0: full timing (busy, done) still observed; q unchanged.
- rst asserted mid-EXEC: immediate return to the reset values above; the in-flight command is discarded with no done. After rst deasserts, a requester still holding valid is arbitrated afresh.
- No X propagation: q is always a defined function of the reset value and the applied ops.

Test Plan:
1. Hold rst=1 for 2 edges while req0_valid=1 -> q=0x00, busy=0, done=0, grant_id=0, no acceptance. Release rst: req0_ready=1 next cycle.
2. From q=0x00, req0 set, mask 0xF0, rpt 0 -> accept edge, next edge q=0xF0. busy high 1 cycle, done high 1 cycle, grant_id=0.
3. From q=0xF0, req1 toggle, mask 0x0F, rpt 2 -> q=0xFF, 0xF0, 0xFF on successive edges. done once after third edge. req0_ready and req1_ready low throughout EXEC.
4. Both valid held continuously after reset, each with set/reset of bit 0, rpt 0 -> grants in order 0,1,0,1 (grant_id follows). Each new accept occurs in the cycle done is high. q[0] alternates 1,0,1,0.
5. req0 hold, mask 0xFF, rpt 15 (CNT_W=4), q=0xA5 -> busy 16 cycles, q stays 0xA5, single done pulse. Repeat with reset op, mask 0xFF -> q=0x00 after first application.
6. req1 toggle, mask 0xFF, rpt 7; assert rst asynchronously after 3 applications -> q=0x00, busy=0 immediately, no done. After release with req1_valid still high -> req1 re-accepted and 8 full toggles executed from 0x00, ending q=0x00.
